// File: rtl/hamming_dec_engine.sv
// SECDED decoder engine: reads 16-bit codewords from byte memory, writes 11-bit data plus 2-bit status.
// Optional macro HAMDEC_STATS_EN adds saturating single/double error counters.
module hamming_dec_engine #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata
`ifdef HAMDEC_STATS_EN
    ,
    output logic [7:0]        single_cnt,
    output logic [7:0]        double_cnt
`endif
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP_HI, DEC, WR_LO, WR_HI, DONE} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        cw_lo, cw_hi;
    logic [7:0]        res_lo, res_hi;
    logic [15:0]       cw;
    logic [3:0]        syn;
    logic              par;
    logic [1:0]        flags;
    logic [10:0]       data;
    logic [ADDR_W-1:0] offs;
    logic              last;

    assign cw   = {cw_hi, cw_lo};
    assign offs = ADDR_W'({idx, 1'b0});
    assign last = (idx == IDX_W'(NUM_WORDS - 1));

    // Each syndrome bit is the parity over the positions whose index has that bit set
    always_comb begin
        syn[0] = ^(cw & 16'hAAAA);
        syn[1] = ^(cw & 16'hCCCC);
        syn[2] = ^(cw & 16'hF0F0);
        syn[3] = ^(cw & 16'hFF00);
        par    = ^cw;
        flags  = 2'b00;
        data   = {cw[15:9], cw[7:5], cw[3]};
        if (par) begin
            flags = 2'b01;
            case (syn)
                4'd3:    data[0]  = ~data[0];
                4'd5:    data[1]  = ~data[1];
                4'd6:    data[2]  = ~data[2];
                4'd7:    data[3]  = ~data[3];
                4'd9:    data[4]  = ~data[4];
                4'd10:   data[5]  = ~data[5];
                4'd11:   data[6]  = ~data[6];
                4'd12:   data[7]  = ~data[7];
                4'd13:   data[8]  = ~data[8];
                4'd14:   data[9]  = ~data[9];
                4'd15:   data[10] = ~data[10];
                default: ;
            endcase
        end else if (syn != 4'd0) begin
            flags = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            cw_lo  <= '0;
            cw_hi  <= '0;
            res_lo <= '0;
            res_hi <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    idx  <= '0;
                    done <= 1'b0;
                end
                RD_HI:  cw_lo <= mem_rdata;
                CAP_HI: cw_hi <= mem_rdata;
                DEC: begin
                    res_lo <= data[7:0];
                    res_hi <= {flags, 3'b000, data[10:8]};
                end
                WR_HI:  if (!last) idx <= idx + IDX_W'(1);
                DONE:   done <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE:   if (start) state_nxt = RD_LO;
            RD_LO: begin
                mem_rd_en = 1'b1;
                mem_addr  = ADDR_W'(SRC_BASE) + offs;
                state_nxt = RD_HI;
            end
            RD_HI: begin
                mem_rd_en = 1'b1;
                mem_addr  = ADDR_W'(SRC_BASE) + offs + ADDR_W'(1);
                state_nxt = CAP_HI;
            end
            CAP_HI: state_nxt = DEC;
            DEC:    state_nxt = WR_LO;
            WR_LO: begin
                mem_wr_en = 1'b1;
                mem_addr  = ADDR_W'(DST_BASE) + offs;
                mem_wdata = res_lo;
                state_nxt = WR_HI;
            end
            WR_HI: begin
                mem_wr_en = 1'b1;
                mem_addr  = ADDR_W'(DST_BASE) + offs + ADDR_W'(1);
                mem_wdata = res_hi;
                state_nxt = last ? DONE : RD_LO;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef HAMDEC_STATS_EN
    // Counters freeze once the last word is decoded, so they are stable while done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else if (state == IDLE && start) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else if (state == DEC) begin
            if (flags == 2'b01 && single_cnt != 8'hFF) single_cnt <= single_cnt + 8'd1;
            if (flags == 2'b10 && double_cnt != 8'hFF) double_cnt <= double_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Self-checking bench for hamming_dec_engine: byte memory model, golden SECDED decode and a cycle schedule model.
module tb_hamming_dec_engine;
    localparam int N   = 15;
    localparam int SRC = 30;
    localparam int DST = 0;
    localparam int LAT = 6 * N + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
`ifdef HAMDEC_STATS_EN
    logic [7:0] single_cnt, double_cnt;
    int         exp_single, exp_double;
`endif

    logic       load_en = 1'b0;
    logic [7:0] load_addr = 8'h00;
    logic [7:0] load_data = 8'h00;
    logic [7:0] mem [256];

    logic [15:0] words [N];
    logic [15:0] expect_res [N];

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    hamming_dec_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
`ifdef HAMDEC_STATS_EN
        ,
        .single_cnt(single_cnt),
        .double_cnt(double_cnt)
`endif
    );

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    function automatic bit is_pow2(input int i);
        return (i & (i - 1)) == 0;
    endfunction

    // Reference decode written straight from the position/parity definition
    function automatic logic [15:0] golden(input logic [15:0] c);
        int s;
        int p;
        int k;
        logic [15:0] f;
        logic [10:0] d;
        logic [1:0]  fl;
        s = 0;
        p = 0;
        k = 0;
        d = '0;
        for (int i = 1; i < 16; i++) if (c[i]) s = s ^ i;
        for (int i = 0; i < 16; i++) p = p ^ int'(c[i]);
        f = c;
        if (p == 1 && s != 0) f[s] = ~f[s];
        fl = (p == 1) ? 2'b01 : ((s != 0) ? 2'b10 : 2'b00);
        for (int i = 1; i < 16; i++) begin
            if (!is_pow2(i)) begin
                d[k] = f[i];
                k++;
            end
        end
        return {fl, 3'b000, d[10:8], d[7:0]};
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        int k;
        int s;
        c = '0;
        k = 0;
        s = 0;
        for (int i = 1; i < 16; i++) begin
            if (!is_pow2(i)) begin
                c[i] = d[k];
                k++;
            end
        end
        for (int i = 1; i < 16; i++) if (c[i]) s = s ^ i;
        for (int b = 0; b < 4; b++) if (s[b]) c[1 << b] = 1'b1;
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [15:0] random_word();
        logic [15:0] c;
        int nflip;
        int a;
        int b;
        c = encode(11'($urandom));
        nflip = $urandom_range(0, 2);
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        if (nflip >= 1) c[a] = ~c[a];
        if (nflip == 2) c[b] = ~c[b];
        return c;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle schedule model: after an accepted start there are 6*N word cycles, one DONE cycle, then done
    bit mbusy = 1'b0;
    int mk = 0;
    bit mdone = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy <= 1'b0;
            mk    <= 0;
            mdone <= 1'b0;
        end else if (!mbusy) begin
            if (start) begin
                mbusy <= 1'b1;
                mk    <= 0;
                mdone <= 1'b0;
            end
        end else if (mk == 6 * N) begin
            mbusy <= 1'b0;
            mdone <= 1'b1;
        end else begin
            mk <= mk + 1;
        end
    end

    int          cw_w, ph;
    bit          erd, ewr;
    logic [7:0]  eaddr, ewd;
    logic [15:0] gres;
    always @(negedge clk) begin
        if (checking) begin
            erd   = 1'b0;
            ewr   = 1'b0;
            eaddr = 8'h00;
            ewd   = 8'h00;
            if (rst_n && mbusy && mk < 6 * N) begin
                cw_w = mk / 6;
                ph   = mk % 6;
                gres = golden({mem[8'(SRC + 2 * cw_w + 1)], mem[8'(SRC + 2 * cw_w)]});
                case (ph)
                    0: begin erd = 1'b1; eaddr = 8'(SRC + 2 * cw_w); end
                    1: begin erd = 1'b1; eaddr = 8'(SRC + 2 * cw_w + 1); end
                    4: begin ewr = 1'b1; eaddr = 8'(DST + 2 * cw_w); ewd = gres[7:0]; end
                    5: begin ewr = 1'b1; eaddr = 8'(DST + 2 * cw_w + 1); ewd = gres[15:8]; end
                    default: ;
                endcase
            end
            checkOutput("done", int'(done), int'(mdone));
            checkOutput("rd_en", int'(mem_rd_en), int'(erd));
            checkOutput("wr_en", int'(mem_wr_en), int'(ewr));
            if (erd || ewr) checkOutput("addr", int'(mem_addr), int'(eaddr));
            if (ewr) checkOutput("wdata", int'(mem_wdata), int'(ewd));
        end
    end

    task automatic loadWords();
        for (int w = 0; w < N; w++) begin
            for (int b = 0; b < 2; b++) begin
                @(posedge clk);
                #1;
                load_en   = 1'b1;
                load_addr = 8'(SRC + 2 * w + b);
                load_data = (b == 0) ? words[w][7:0] : words[w][15:8];
            end
        end
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int already);
        int cnt;
        cnt = already;
        while (!done && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput(name, cnt, LAT);
    endtask

    task automatic verifyResults(input string tag);
        for (int w = 0; w < N; w++)
            checkOutput($sformatf("%s_word%0d", tag, w),
                        int'({mem[8'(DST + 2 * w + 1)], mem[8'(DST + 2 * w)]}), int'(expect_res[w]));
`ifdef HAMDEC_STATS_EN
        exp_single = 0;
        exp_double = 0;
        for (int w = 0; w < N; w++) begin
            if (expect_res[w][15:14] == 2'b01) exp_single++;
            if (expect_res[w][15:14] == 2'b10) exp_double++;
        end
        checkOutput({tag, "_single_cnt"}, int'(single_cnt), exp_single);
        checkOutput({tag, "_double_cnt"}, int'(double_cnt), exp_double);
`endif
    endtask

    task automatic randomJob();
        for (int w = 0; w < N; w++) begin
            words[w]      = random_word();
            expect_res[w] = golden(words[w]);
        end
    endtask

    initial begin
        int found;

        #1;
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_rd_en", int'(mem_rd_en), 0);
        checkOutput("reset_wr_en", int'(mem_wr_en), 0);
        checkOutput("reset_addr", int'(mem_addr), 0);
        checkOutput("reset_wdata", int'(mem_wdata), 0);

        checkOutput("model_0000", int'(golden(16'h0000)), 16'h0000);
        checkOutput("model_ffff", int'(golden(16'hFFFF)), 16'h07FF);
        checkOutput("model_ffdf", int'(golden(16'hFFDF)), 16'h47FF);
        checkOutput("model_fffe", int'(golden(16'hFFFE)), 16'h47FF);
        checkOutput("model_ff9f", int'(golden(16'hFF9F)), 16'h87F9);

        @(negedge clk);
        rst_n = 1'b1;
        checking = 1'b1;

        // Job 1: directed corner codewords followed by random encoded words
        randomJob();
        words[0] = 16'h0000; expect_res[0] = 16'h0000;
        words[1] = 16'hFFFF; expect_res[1] = 16'h07FF;
        words[2] = 16'hFFDF; expect_res[2] = 16'h47FF;
        words[3] = 16'hFFFE; expect_res[3] = 16'h47FF;
        words[4] = 16'hFF9F; expect_res[4] = 16'h87F9;
        loadWords();
        applyStimulus();
        waitDone("job1_latency", 0);
        verifyResults("job1");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_held", int'(done), 1);

        // Job 2: new start while done is high, plus a start pulse while busy that must be ignored
        randomJob();
        loadWords();
        checkOutput("done_held_before_start", int'(done), 1);
        applyStimulus();
        checkOutput("done_cleared_on_start", int'(done), 0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("job2_latency", 11);
        verifyResults("job2");

        // Job 3: reset at word 7, then restart from word 0
        randomJob();
        loadWords();
        applyStimulus();
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(posedge clk);
            #1;
            if (mem_rd_en && mem_addr == 8'(SRC + 14)) found = 1;
        end
        checkOutput("reach_word7", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_rd_en", int'(mem_rd_en), 0);
        checkOutput("midreset_wr_en", int'(mem_wr_en), 0);
        checkOutput("midreset_addr", int'(mem_addr), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus();
        waitDone("job3_latency", 0);
        verifyResults("job3");

        repeat (2) @(posedge clk);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
